regfile_bank: RTL and testbench

Parametrised register bank with byte-enabled writes, two combinational read ports with optional write-through bypass, and a hardware soft-clear sequencer. It generalises the team's single 32-bit write-enabled register into an N-entry array. It sits between the decode stage (read addresses) and the write-back stage (write port) of the datapath.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/byte_merge.sv | 21 ++
 rtl/regfile_bank.sv | 106 ++++++++++
 tb/tb_regfile_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register bank.
// Latency: n/a (declarations and a pure combinational helper).
// Backpressure: n/a.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Soft-clear sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Byte-wise merge at the default width: bytes with be=1 come from new_v.
  function automatic logic [DEF_DATA_W-1:0] merge(
    input logic [DEF_DATA_W-1:0]   old_v,
    input logic [DEF_DATA_W-1:0]   new_v,
    input logic [DEF_DATA_W/8-1:0] be
  );
    logic [DEF_DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < DEF_DATA_W / 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Byte-enabled merge of new data over an existing word.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: cur (existing word), upd (incoming word), be (one bit per byte),
//        merged (upd bytes where be=1, cur bytes elsewhere).
module byte_merge
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]   cur,
  input  logic [DATA_W-1:0]   upd,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_byte
    assign merged[8*i +: 8] = be[i] ? upd[8*i +: 8] : cur[8*i +: 8];
  end

endmodule

// File: rtl/regfile_bank.sv
// N-entry register bank: byte-enabled write port, two combinational read ports, soft clear.
// Latency: write visible 1 edge later via storage, same cycle via bypass; WAck 1 cycle after accept.
// Backpressure: none; writes arriving while Busy=1 are dropped (no WAck), Clr while Busy ignored.
// Ports: CLK/Reset (async active-low); WE/WAddr/Data/BE write port; RAddrA/RAddrB -> DoutA/DoutB
//        combinational reads; Clr starts a one-entry-per-cycle zeroing pass, Busy marks it;
//        WAck pulses for one cycle after each accepted write.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,  // multiple of 8
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WAddr,
  input  logic [DATA_W-1:0]   Data,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   RAddrA,
  input  logic [ADDR_W-1:0]   RAddrB,
  output logic [DATA_W-1:0]   DoutA,
  output logic [DATA_W-1:0]   DoutB,
  input  logic                Clr,
  output logic                Busy,
  output logic                WAck
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wack_q;
  logic              wr_acc;
  logic              wr_zero;
  logic [DATA_W-1:0] wr_merged;
  logic              hit_a, hit_b;

  assign Busy    = (state_q == CLEAR);
  assign WAck    = wack_q;
  assign wr_acc  = WE && !Busy;
  // Writes to a hardwired-zero entry are acknowledged but never stored.
  assign wr_zero = (ZERO_R0 != 0) && (WAddr == '0);

  // Single merge instance; the bypass path reuses its output.
  byte_merge #(.DATA_W(DATA_W)) u_merge (
    .cur    (mem[WAddr]),
    .upd    (Data),
    .be     (BE),
    .merged (wr_merged)
  );

  // Clear sequencer: one entry per edge, returning to IDLE on the last entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wack_q  <= wr_acc;
    end
  end

  // Storage. A write and a clear never coincide since writes require !Busy.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_acc && !wr_zero) begin
      mem[WAddr] <= wr_merged;
    end
  end

  // Bypass only on an accepted write; the zero-entry override below wins.
  assign hit_a = (BYPASS != 0) && wr_acc && (RAddrA == WAddr);
  assign hit_b = (BYPASS != 0) && wr_acc && (RAddrB == WAddr);

  assign DoutA = ((ZERO_R0 != 0) && (RAddrA == '0)) ? '0 :
                 hit_a ? wr_merged : mem[RAddrA];
  assign DoutB = ((ZERO_R0 != 0) && (RAddrB == '0)) ? '0 :
                 hit_b ? wr_merged : mem[RAddrB];

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: default instance plus a BYPASS=0 / ZERO_R0=0 instance
// driven by the same stimulus. Inputs change 1 time unit after the rising edge and are
// checked before the next one.
module tb_regfile_bank;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  WAddr = '0;
  logic [31:0] Data = '0;
  logic [3:0]  BE = '0;
  logic [4:0]  RAddrA = '0;
  logic [4:0]  RAddrB = '0;
  logic        Clr = 1'b0;
  logic [31:0] DoutA, DoutB, DoutA_nb, DoutB_nb;
  logic        Busy, WAck, Busy_nb, WAck_nb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  regfile_bank u_dut (
    .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .Data(Data), .BE(BE),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .DoutA(DoutA), .DoutB(DoutB),
    .Clr(Clr), .Busy(Busy), .WAck(WAck)
  );

  regfile_bank #(.ZERO_R0(0), .BYPASS(0)) u_dut_nb (
    .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .Data(Data), .BE(BE),
    .RAddrA(RAddrA), .RAddrB(RAddrB), .DoutA(DoutA_nb), .DoutB(DoutB_nb),
    .Clr(Clr), .Busy(Busy_nb), .WAck(WAck_nb)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    WE = 1'b1; WAddr = a; Data = d; BE = b;
    step();
    WE = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int cnt;

    // Reset held from time 0.
    RAddrA = 5'd5;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_wack", 32'(WAck), 32'd0);
    check("rst_rd5", DoutA, 32'h0);
    Reset = 1'b1;
    step();

    // Asynchronous reset mid-cycle wipes contents and WAck.
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    #1;
    check("pre_rst_rd5", DoutA, 32'hDEADBEEF);
    check("pre_rst_wack", 32'(WAck), 32'd1);
    Reset = 1'b0;
    #1;
    check("async_rst_rd5", DoutA, 32'h0);
    check("async_rst_rd5_nb", DoutA_nb, 32'h0);
    check("async_rst_wack", 32'(WAck), 32'd0);
    check("async_rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    step();

    // Byte enables.
    RAddrA = 5'd3;
    wr(5'd3, 32'h11223344, 4'hF);
    wr(5'd3, 32'hAABBCCDD, 4'b0101);
    check("be_wack", 32'(WAck), 32'd1);
    check("be_rd3", DoutA, 32'h11BB33DD);
    step();
    check("be_wack_pulse", 32'(WAck), 32'd0);

    // Full-word bypass vs. storage-only path.
    RAddrA = 5'd7;
    WE = 1'b1; WAddr = 5'd7; Data = 32'h12345678; BE = 4'hF;
    #1;
    check("byp_same_cycle", DoutA, 32'h12345678);
    check("nobyp_same_cycle", DoutA_nb, 32'h0);
    step();
    WE = 1'b0;
    check("byp_next", DoutA, 32'h12345678);
    check("nobyp_next", DoutA_nb, 32'h12345678);

    // Partial bypass merges with the stored word.
    RAddrB = 5'd7;
    WE = 1'b1; WAddr = 5'd7; Data = 32'hAAAABBBB; BE = 4'b0011;
    #1;
    check("byp_partial", DoutB, 32'h1234BBBB);
    check("nobyp_partial_old", DoutB_nb, 32'h12345678);
    step();
    WE = 1'b0;
    check("nobyp_partial_next", DoutB_nb, 32'h1234BBBB);

    // Entry 0.
    RAddrA = 5'd0;
    WE = 1'b1; WAddr = 5'd0; Data = 32'hFFFFFFFF; BE = 4'hF;
    #1;
    check("r0_no_bypass", DoutA, 32'h0);
    step();
    WE = 1'b0;
    check("r0_wack", 32'(WAck), 32'd1);
    check("r0_reads_zero", DoutA, 32'h0);
    check("r0_writable_nb", DoutA_nb, 32'hFFFFFFFF);

    // Soft clear over a filled bank.
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 1), 4'hF);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    busy_cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      if (Busy) busy_cycles++;
      if (c == 1) check("clr_busy_rise", 32'(Busy), 32'd1);
      if (c == 3) begin
        WE = 1'b1; WAddr = 5'd20; Data = 32'h0BAD0BAD; BE = 4'hF; RAddrA = 5'd20;
        #1;
        check("clr_no_bypass", DoutA, 32'd21);
      end
      if (c == 4) begin
        WE = 1'b0;
        check("clr_we_dropped", 32'(WAck), 32'd0);
      end
      if (c == 5) Clr = 1'b1;
      if (c == 6) Clr = 1'b0;
      if (c == 10) begin
        RAddrA = 5'd8; RAddrB = 5'd20;
        #1;
        check("clr_c10_e8", DoutA, 32'h0);
        check("clr_c10_e20", DoutB, 32'd21);
        RAddrA = 5'd9;
        #1;
        check("clr_c10_e9", DoutA, 32'd10);
      end
      if (c == 32) check("clr_busy_last", 32'(Busy), 32'd1);
      if (c == 33) check("clr_busy_fall", 32'(Busy), 32'd0);
      step();
    end
    check("clr_busy_len", 32'(busy_cycles), 32'd32);
    for (int i = 0; i < 32; i++) begin
      RAddrA = 5'(i);
      #1;
      check($sformatf("post_clr_e%0d", i), DoutA, 32'h0);
      check($sformatf("post_clr_nb_e%0d", i), DoutA_nb, 32'h0);
    end
    step();

    // Write and Clr sampled on the same edge.
    RAddrA = 5'd12;
    WE = 1'b1; WAddr = 5'd12; Data = 32'hCAFEF00D; BE = 4'hF; Clr = 1'b1;
    step();
    WE = 1'b0; Clr = 1'b0;
    check("wc_wack", 32'(WAck), 32'd1);
    check("wc_busy", 32'(Busy), 32'd1);
    check("wc_written", DoutA, 32'hCAFEF00D);
    cnt = 1;
    for (int i = 0; i < 100 && Busy; i++) begin
      step();
      if (Busy) cnt++;
    end
    check("wc_busy_len", 32'(cnt), 32'd32);
    check("wc_busy_done", 32'(Busy), 32'd0);
    check("wc_entry_cleared", DoutA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
